// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared machine-cycle type codes and helpers for the Z80 bus sequencer.
// The refresh feature is enabled by defining BUS_CYCLE_REFRESH_EN.
package bus_cycle_ctrl_pkg;

  localparam int CYC_TYPE_WIDTH = 3;

  typedef logic [CYC_TYPE_WIDTH-1:0] cyc_type_t;

  localparam cyc_type_t CYC_M1     = 3'd0;
  localparam cyc_type_t CYC_MEM_RD = 3'd1;
  localparam cyc_type_t CYC_MEM_WR = 3'd2;
  localparam cyc_type_t CYC_IO_RD  = 3'd3;
  localparam cyc_type_t CYC_IO_WR  = 3'd4;

  function automatic logic is_io(input cyc_type_t t);
    return (t == CYC_IO_RD) || (t == CYC_IO_WR);
  endfunction

  function automatic logic is_mem(input cyc_type_t t);
    return (t == CYC_MEM_RD) || (t == CYC_MEM_WR);
  endfunction

  function automatic logic is_rd(input cyc_type_t t);
    return (t == CYC_MEM_RD) || (t == CYC_IO_RD);
  endfunction

  function automatic logic is_wr(input cyc_type_t t);
    return (t == CYC_MEM_WR) || (t == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_refresh_ctr.sv
// 7-bit DRAM refresh (R) counter; only used when BUS_CYCLE_REFRESH_EN
// is defined.
module refresh_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [6:0] r
);

  logic [6:0] r_q;
  logic [6:0] r_d;

  always_comb begin
    r_d = r_q;
    if (inc) r_d = r_q + 7'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign r = r_q;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Z80 external bus cycle sequencer: T-states, waits, strobes, data capture.
// Define BUS_CYCLE_REFRESH_EN for R counter and M1 refresh addressing.
module bus_cycle_ctrl
  import bus_cycle_ctrl_pkg::*;
#(
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc_start,
  input  logic [2:0]  cyc_type,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic [7:0]  i_reg,
  output logic [7:0]  din,
  output logic        cyc_done,
  output logic        busy,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_m1,
  output logic        n_mreq,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_rfsh,
  input  logic        n_wait
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TWA  = 3'd3,
    S_TW   = 3'd4,
    S_T3   = 3'd5,
    S_T4   = 3'd6
  } tstate_e;

  localparam logic [1:0] AW_LAST =
    2'((IO_AUTO_WAIT > 0) ? IO_AUTO_WAIT - 1 : 0);
  localparam logic AW_EN = (IO_AUTO_WAIT > 0);

  tstate_e     state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  cyc_type_t   type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  din_q, din_d;
  logic [15:0] a_q, a_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        d_oe_q, d_oe_d;
  logic        n_m1_q, n_m1_d;
  logic        n_mreq_q, n_mreq_d;
  logic        n_iorq_q, n_iorq_d;
  logic        n_rd_q, n_rd_d;
  logic        n_wr_q, n_wr_d;

  logic final_st;
  logic accept;
  logic m1_n;
  logic act;
  logic early;
  logic late;

  assign final_st = (state_q == S_T4) ||
                    ((state_q == S_T3) && (type_q != CYC_M1));
  assign accept   = cyc_start && ((state_q == S_IDLE) || final_st);

`ifdef BUS_CYCLE_REFRESH_EN
  logic [6:0] r;
  logic       r_inc;
  logic       n_rfsh_q, n_rfsh_d;

  assign r_inc = (type_q == CYC_M1) && (state_q != S_T3) &&
                 (state_d == S_T3);

  refresh_ctr u_rctr (
    .clk   (clk),
    .reset (reset),
    .inc   (r_inc),
    .r     (r)
  );
`else
  logic unused_i_reg;
  assign unused_i_reg = ^i_reg;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    din_d   = din_q;
    unique case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (is_io(type_q) && AW_EN) begin
          state_d = S_TWA;
          wcnt_d  = AW_LAST;
        end else begin
          state_d = n_wait ? S_T3 : S_TW;
        end
      end
      S_TWA: begin
        if (wcnt_q != 2'd0) wcnt_d  = wcnt_q - 2'd1;
        else                state_d = n_wait ? S_T3 : S_TW;
      end
      S_TW:   state_d = n_wait ? S_T3 : S_TW;
      S_T3:   state_d = (type_q == CYC_M1) ? S_T4 : S_IDLE;
      S_T4:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // M1 latches opcode entering T3; other reads latch leaving T3
    if ((type_q == CYC_M1) && (state_d == S_T3) &&
        ((state_q == S_T2) || (state_q == S_TW)))
      din_d = d_in;
    if ((state_q == S_T3) && is_rd(type_q))
      din_d = d_in;
    if (accept) begin
      state_d = S_T1;
      type_d  = cyc_type;
      addr_d  = addr;
      dout_d  = dout;
    end
  end

  assign m1_n  = (type_d == CYC_M1);
  assign act   = (state_d == S_T1) || (state_d == S_T2) ||
                 (state_d == S_TWA) || (state_d == S_TW) ||
                 (state_d == S_T3);
  assign early = (state_d == S_T1) || (state_d == S_T2) ||
                 (state_d == S_TW);
  assign late  = (state_d == S_T2) || (state_d == S_TWA) ||
                 (state_d == S_TW) || (state_d == S_T3);

  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_T4) ||
               ((state_d == S_T3) && !m1_n);
    n_m1_d   = !(m1_n && early);
    n_mreq_d = !((m1_n && early) || (is_mem(type_d) && act));
    n_rd_d   = !((m1_n && early) ||
                 ((type_d == CYC_MEM_RD) && act) ||
                 ((type_d == CYC_IO_RD) && late));
    n_wr_d   = !(is_wr(type_d) && late);
    n_iorq_d = !(is_io(type_d) && late);
    d_oe_d   = is_wr(type_d) && act;
    a_d      = a_q;
    if (act) a_d = addr_d;
`ifdef BUS_CYCLE_REFRESH_EN
    n_rfsh_d = !(m1_n && ((state_d == S_T3) || (state_d == S_T4)));
    if (m1_n && (state_d == S_T3)) begin
      n_mreq_d = 1'b0;
      if (state_q != S_T3) a_d = {i_reg, 1'b0, r};
      else                 a_d = a_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      type_q   <= CYC_M1;
      addr_q   <= '0;
      dout_q   <= '0;
      din_q    <= '0;
      a_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      n_m1_q   <= 1'b1;
      n_mreq_q <= 1'b1;
      n_iorq_q <= 1'b1;
      n_rd_q   <= 1'b1;
      n_wr_q   <= 1'b1;
`ifdef BUS_CYCLE_REFRESH_EN
      n_rfsh_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      din_q    <= din_d;
      a_q      <= a_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      d_oe_q   <= d_oe_d;
      n_m1_q   <= n_m1_d;
      n_mreq_q <= n_mreq_d;
      n_iorq_q <= n_iorq_d;
      n_rd_q   <= n_rd_d;
      n_wr_q   <= n_wr_d;
`ifdef BUS_CYCLE_REFRESH_EN
      n_rfsh_q <= n_rfsh_d;
`endif
    end
  end

  assign din      = din_q;
  assign cyc_done = done_q;
  assign busy     = busy_q;
  assign a        = a_q;
  assign d_out    = dout_q;
  assign d_oe     = d_oe_q;
  assign n_m1     = n_m1_q;
  assign n_mreq   = n_mreq_q;
  assign n_iorq   = n_iorq_q;
  assign n_rd     = n_rd_q;
  assign n_wr     = n_wr_q;
`ifdef BUS_CYCLE_REFRESH_EN
  assign n_rfsh   = n_rfsh_q;
`else
  assign n_rfsh   = 1'b1;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl; strobes packed as
// {busy,cyc_done,n_m1,n_mreq,n_iorq,n_rd,n_wr,n_rfsh,d_oe}.
module tb_bus_cycle_ctrl;
  import bus_cycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc_start;
  logic [2:0]  cyc_type;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  i_reg;
  logic [7:0]  din;
  logic        cyc_done;
  logic        busy;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh;
  logic        n_wait;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0]  r_model = '0;
  logic [15:0] last_a;

  localparam logic [8:0] V_IDLE = 9'b0_0_1_1_1_1_1_1_0;
  localparam logic [8:0] V_M1A  = 9'b1_0_0_0_1_0_1_1_0;
`ifdef BUS_CYCLE_REFRESH_EN
  localparam logic [8:0] V_M1T3 = 9'b1_0_1_0_1_1_1_0_0;
  localparam logic [8:0] V_M1T4 = 9'b1_1_1_1_1_1_1_0_0;
`else
  localparam logic [8:0] V_M1T3 = 9'b1_0_1_1_1_1_1_1_0;
  localparam logic [8:0] V_M1T4 = 9'b1_1_1_1_1_1_1_1_0;
`endif
  localparam logic [8:0] V_WR1  = 9'b1_0_1_0_1_1_1_1_1;
  localparam logic [8:0] V_WR2  = 9'b1_0_1_0_1_1_0_1_1;
  localparam logic [8:0] V_WR3  = 9'b1_1_1_0_1_1_0_1_1;
  localparam logic [8:0] V_IO1  = 9'b1_0_1_1_1_1_1_1_0;
  localparam logic [8:0] V_IO2  = 9'b1_0_1_1_0_0_1_1_0;
  localparam logic [8:0] V_IO3  = 9'b1_1_1_1_0_0_1_1_0;
  localparam logic [8:0] V_RD1  = 9'b1_0_1_0_1_0_1_1_0;
  localparam logic [8:0] V_RD3  = 9'b1_1_1_0_1_0_1_1_0;

  bus_cycle_ctrl #(.IO_AUTO_WAIT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .cyc_start (cyc_start),
    .cyc_type  (cyc_type),
    .addr      (addr),
    .dout      (dout),
    .i_reg     (i_reg),
    .din       (din),
    .cyc_done  (cyc_done),
    .busy      (busy),
    .a         (a),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .d_in      (d_in),
    .n_m1      (n_m1),
    .n_mreq    (n_mreq),
    .n_iorq    (n_iorq),
    .n_rd      (n_rd),
    .n_wr      (n_wr),
    .n_rfsh    (n_rfsh),
    .n_wait    (n_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] strb();
    return {busy, cyc_done, n_m1, n_mreq, n_iorq,
            n_rd, n_wr, n_rfsh, d_oe};
  endfunction

  function automatic logic [15:0] m1_ref(input logic [15:0] ad);
`ifdef BUS_CYCLE_REFRESH_EN
    return {i_reg, 1'b0, r_model};
`else
    return ad;
`endif
  endfunction

  initial begin
    reset = 1'b1; cyc_start = 1'b0; cyc_type = CYC_M1;
    addr = '0; dout = '0; i_reg = 8'h5A; d_in = '0; n_wait = 1'b1;
    tick; tick;
    chk("rst_strb", 32'(strb()), 32'(V_IDLE));
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_dout", 32'(d_out), 32'h0);
    chk("rst_din", 32'(din), 32'h0);
    reset = 1'b0;
    tick;
    chk("idle_strb", 32'(strb()), 32'(V_IDLE));

    cyc_start = 1'b1; cyc_type = CYC_M1;
    addr = 16'h1234; d_in = 8'h3E;
    tick; cyc_start = 1'b0;
    chk("m1_t1", 32'(strb()), 32'(V_M1A));
    chk("m1_a1", 32'(a), 32'h1234);
    tick;
    chk("m1_t2", 32'(strb()), 32'(V_M1A));
    tick;
    chk("m1_t3", 32'(strb()), 32'(V_M1T3));
    chk("m1_din", 32'(din), 32'h3E);
    last_a = m1_ref(16'h1234);
    chk("m1_a3", 32'(a), 32'(last_a));
    r_model++;
    tick;
    chk("m1_t4", 32'(strb()), 32'(V_M1T4));
    chk("m1_a4", 32'(a), 32'(last_a));
    tick;
    chk("m1_idle", 32'(strb()), 32'(V_IDLE));
    chk("m1_ahold", 32'(a), 32'(last_a));

    cyc_start = 1'b1; cyc_type = CYC_MEM_WR;
    addr = 16'h8000; dout = 8'hA5;
    tick; cyc_start = 1'b0; dout = 8'h00;
    chk("wr_t1", 32'(strb()), 32'(V_WR1));
    chk("wr_dout", 32'(d_out), 32'hA5);
    chk("wr_a", 32'(a), 32'h8000);
    tick;
    chk("wr_t2", 32'(strb()), 32'(V_WR2));
    n_wait = 1'b0;
    tick;
    chk("wr_tw1", 32'(strb()), 32'(V_WR2));
    tick;
    chk("wr_tw2", 32'(strb()), 32'(V_WR2));
    n_wait = 1'b1;
    tick;
    chk("wr_t3", 32'(strb()), 32'(V_WR3));
    chk("wr_dout3", 32'(d_out), 32'hA5);
    tick;
    chk("wr_idle", 32'(strb()), 32'(V_IDLE));

    cyc_start = 1'b1; cyc_type = CYC_IO_RD;
    addr = 16'h00FE; d_in = 8'h7F;
    tick; cyc_start = 1'b0;
    chk("io_t1", 32'(strb()), 32'(V_IO1));
    chk("io_a", 32'(a), 32'h00FE);
    tick;
    chk("io_t2", 32'(strb()), 32'(V_IO2));
    tick;
    chk("io_twa", 32'(strb()), 32'(V_IO2));
    tick;
    chk("io_t3", 32'(strb()), 32'(V_IO3));
    chk("io_din_old", 32'(din), 32'h3E);
    tick;
    chk("io_idle", 32'(strb()), 32'(V_IDLE));
    chk("io_din", 32'(din), 32'h7F);

    cyc_start = 1'b1; cyc_type = CYC_M1;
    addr = 16'h0100; d_in = 8'h11;
    tick;
    chk("b2b_t1", 32'(strb()), 32'(V_M1A));
    cyc_type = CYC_IO_WR;
    tick; cyc_start = 1'b0; cyc_type = CYC_M1;
    chk("b2b_ign", 32'(strb()), 32'(V_M1A));
    tick;
    chk("b2b_t3", 32'(strb()), 32'(V_M1T3));
    chk("b2b_din", 32'(din), 32'h11);
    chk("b2b_a3", 32'(a), 32'(m1_ref(16'h0100)));
    r_model++;
    tick;
    chk("b2b_t4", 32'(strb()), 32'(V_M1T4));
    cyc_start = 1'b1; cyc_type = CYC_MEM_RD;
    addr = 16'h2000; d_in = 8'h42;
    tick; cyc_start = 1'b0;
    chk("b2b_rd1", 32'(strb()), 32'(V_RD1));
    chk("b2b_rda", 32'(a), 32'h2000);
    tick;
    chk("b2b_rd2", 32'(strb()), 32'(V_RD1));
    tick;
    chk("b2b_rd3", 32'(strb()), 32'(V_RD3));
    chk("b2b_rdold", 32'(din), 32'h11);
    tick;
    chk("b2b_idle", 32'(strb()), 32'(V_IDLE));
    chk("b2b_din", 32'(din), 32'h42);

    cyc_start = 1'b1; cyc_type = CYC_MEM_WR;
    addr = 16'h4000; dout = 8'h3C;
    tick; cyc_start = 1'b0;
    tick; n_wait = 1'b0;
    tick;
    chk("ab_tw", 32'(strb()), 32'(V_WR2));
    reset = 1'b1;
    tick;
    chk("ab_strb", 32'(strb()), 32'(V_IDLE));
    chk("ab_a", 32'(a), 32'h0);
    chk("ab_dout", 32'(d_out), 32'h0);
    chk("ab_din", 32'(din), 32'h0);
    r_model = '0;
    reset = 1'b0; n_wait = 1'b1;
    tick;
    chk("ab_nodone", 32'(strb()), 32'(V_IDLE));

    cyc_start = 1'b1; cyc_type = CYC_M1;
    addr = 16'hC3C3; i_reg = 8'h81; d_in = 8'h00;
    tick;
    for (int i = 0; i < 130; i++) begin
      tick;
      tick;
      chk("m1x_a", 32'(a), 32'(m1_ref(16'hC3C3)));
      r_model++;
      tick;
      chk("m1x_t4", 32'(strb()), 32'(V_M1T4));
      if (i == 129) cyc_start = 1'b0;
      tick;
    end
    chk("m1x_idle", 32'(strb()), 32'(V_IDLE));
    chk("m1x_din", 32'(din), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
